// File: rtl/led_bcm_scanner.sv
// HUB75 64x64 1/32-scan BCM scanner: reads pixel pairs from the frame buffer and drives the panel.
// Define LED_BCM_TEST_PATTERN_EN to replace buffer data with a row/column bring-up pattern.
module led_bcm_scanner #(
  parameter int unsigned DELAY   = 1,
  parameter int unsigned PLANES  = 5,
  parameter int unsigned COLUMNS = 64
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_enable,
  output logic [13:0] o_read_addr,
  input  logic [31:0] i_data_out,
  output logic [15:0] o_led_panel,
  output logic        o_frame_done
);

  localparam int unsigned TimerW    = $clog2(DELAY << (PLANES - 1)) + 1;
  localparam logic [5:0]  ColLast   = 6'(COLUMNS - 1);
  localparam logic [2:0]  PlaneLast = 3'(PLANES - 1);
  localparam logic [2:0]  PlaneOff  = 3'(5 - PLANES);
  localparam logic [4:0]  RowLast   = 5'd31;

  typedef enum logic [2:0] {
    StIdle, StFetch, StShift, StBlank, StLatch, StDisplay
  } state_e;

  state_e              r_state, w_state;
  logic [4:0]          r_row, w_row;
  logic [5:0]          r_col, w_col;
  logic [2:0]          r_plane, w_plane;
  logic                r_phase, w_phase;
  logic [TimerW-1:0]   r_timer, w_timer;
  logic [13:0]         r_addr, w_addr;
  logic [5:0]          r_rgb, w_rgb;
  logic [4:0]          r_abcde, w_abcde;
  logic                r_clk, w_clk;
  logic                r_lat, w_lat;
  logic                r_oe_n, w_oe_n;
  logic                r_frame_done, w_frame_done;

  logic [15:0]         w_pix_up, w_pix_lo;
  logic [2:0]          w_bit;
  logic [4:0]          w_r_up, w_g_up, w_b_up, w_r_lo, w_g_lo, w_b_lo;
  logic [5:0]          w_plane_rgb;
  logic [TimerW-1:0]   w_disp_last;
  logic                w_unused_g_lsb;

`ifdef LED_BCM_TEST_PATTERN_EN
  logic w_unused_data;
  assign w_unused_data = ^i_data_out;
  assign w_pix_up      = {r_col[4:0], r_row, 1'b0, 5'b00000};
  assign w_pix_lo      = {5'b00000, 6'b000000, r_col[4:0]};
`else
  assign w_pix_up = i_data_out[15:0];
  assign w_pix_lo = i_data_out[31:16];
`endif

  // Green drops its LSB so every channel contributes its 5 MSBs; fewer planes keep the top bits.
  assign w_bit          = r_plane + PlaneOff;
  assign w_r_up         = w_pix_up[15:11];
  assign w_g_up         = w_pix_up[10:6];
  assign w_b_up         = w_pix_up[4:0];
  assign w_r_lo         = w_pix_lo[15:11];
  assign w_g_lo         = w_pix_lo[10:6];
  assign w_b_lo         = w_pix_lo[4:0];
  assign w_unused_g_lsb = w_pix_up[5] ^ w_pix_lo[5];
  assign w_plane_rgb    = {w_b_lo[w_bit], w_g_lo[w_bit], w_r_lo[w_bit],
                           w_b_up[w_bit], w_g_up[w_bit], w_r_up[w_bit]};
  assign w_disp_last    = TimerW'((DELAY << r_plane) - 1);

  // Outputs are registered from the next state, so each value is visible during its own state.
  always_comb begin
    w_state      = r_state;
    w_row        = r_row;
    w_col        = r_col;
    w_plane      = r_plane;
    w_phase      = r_phase;
    w_timer      = r_timer;
    w_addr       = r_addr;
    w_rgb        = r_rgb;
    w_abcde      = r_abcde;
    w_clk        = 1'b0;
    w_lat        = 1'b0;
    w_oe_n       = 1'b1;
    w_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state = StFetch;
          w_row   = '0;
          w_col   = '0;
          w_plane = '0;
          w_addr  = '0;
        end
      end
      StFetch: begin
        w_state = StShift;
        w_phase = 1'b0;
      end
      StShift: begin
        if (!r_phase) begin
          w_phase = 1'b1;
          w_clk   = 1'b1;
          w_rgb   = w_plane_rgb;
          // Next column's address goes out now so its data lands in the next phase 0.
          if (r_col != ColLast) begin
            w_addr = {3'b000, r_row, r_col + 6'd1};
          end
        end else if (r_col == ColLast) begin
          w_state = StBlank;
          w_col   = '0;
        end else begin
          w_phase = 1'b0;
          w_col   = r_col + 6'd1;
        end
      end
      StBlank: begin
        w_state = StLatch;
        w_lat   = 1'b1;
        w_abcde = r_row;
      end
      StLatch: begin
        w_state = StDisplay;
        w_oe_n  = 1'b0;
        w_timer = w_disp_last;
      end
      StDisplay: begin
        if (r_timer != '0) begin
          w_timer = r_timer - TimerW'(1);
          w_oe_n  = 1'b0;
        end else begin
          w_state = StFetch;
          if (r_plane == PlaneLast) begin
            w_plane = '0;
            w_row   = r_row + 5'd1;
            if (r_row == RowLast) begin
              w_frame_done = 1'b1;
              if (!i_enable) begin
                w_state = StIdle;
              end
            end
          end else begin
            w_plane = r_plane + 3'd1;
          end
          w_addr = {3'b000, w_row, 6'd0};
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state      <= StIdle;
      r_row        <= '0;
      r_col        <= '0;
      r_plane      <= '0;
      r_phase      <= 1'b0;
      r_timer      <= '0;
      r_addr       <= '0;
      r_rgb        <= '0;
      r_abcde      <= '0;
      r_clk        <= 1'b0;
      r_lat        <= 1'b0;
      r_oe_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_row        <= w_row;
      r_col        <= w_col;
      r_plane      <= w_plane;
      r_phase      <= w_phase;
      r_timer      <= w_timer;
      r_addr       <= w_addr;
      r_rgb        <= w_rgb;
      r_abcde      <= w_abcde;
      r_clk        <= w_clk;
      r_lat        <= w_lat;
      r_oe_n       <= w_oe_n;
      r_frame_done <= w_frame_done;
    end
  end

  assign o_read_addr  = r_addr;
  assign o_led_panel  = {2'b00, r_oe_n, r_lat, r_clk, r_abcde, r_rgb};
  assign o_frame_done = r_frame_done;

endmodule
